// File: rtl/booth_mult_unit_pkg.sv
// Shared types and constants for the Booth multiplier slice.
package mult_pkg;

  // Default operand width of the HI/LO multiply unit.
  localparam int MULT_WIDTH_DEFAULT = 32;

  // Sequencer states: the unit is either waiting for work or iterating.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Action selected by the Booth bit pair {q0, q_-1}.
  typedef enum logic [1:0] {
    BOOTH_NOP = 2'b00,
    BOOTH_ADD = 2'b01,
    BOOTH_SUB = 2'b10
  } booth_op_t;

  // Map the low multiplier bit and the previous bit onto the Booth action.
  // 01 marks the end of a run of ones (add), 10 the start of one (subtract).
  function automatic booth_op_t booth_decode(input logic [1:0] pair);
    booth_op_t op;
    case (pair)
      2'b01:   op = BOOTH_ADD;
      2'b10:   op = BOOTH_SUB;
      default: op = BOOTH_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of the multiplicand
// into the high field, followed by an arithmetic right shift of the whole
// accumulator. Purely combinational.
//
// Accumulator layout (2*WIDTH+3 bits):
//   [2*WIDTH+2 : WIDTH+2]  high field (WIDTH+1 bits, signed partial product)
//   [WIDTH+1   : 1]        low field  (WIDTH+1 bits, remaining multiplier)
//   [0]                    q_-1, the previously shifted-out multiplier bit
module booth_step
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
  input  logic [2*WIDTH+2:0] acc_i,
  input  logic [WIDTH:0]     mcand_i,
  output logic [2*WIDTH+2:0] acc_o
);

  logic [WIDTH:0]   highField;
  logic [WIDTH:0]   lowField;
  logic             qPrev;
  logic [WIDTH+1:0] highExt;
  logic [WIDTH+1:0] mcandExt;
  logic [WIDTH+1:0] sum;
  booth_op_t        op;

  assign highField = acc_i[2*WIDTH+2:WIDTH+2];
  assign lowField  = acc_i[WIDTH+1:1];
  assign qPrev     = acc_i[0];

  // Add/subtract one bit wider than the high field so the true sign of the
  // partial product survives, then shift. Concatenating the wide sum with the
  // unshifted low field is exactly the shifted accumulator: sum[WIDTH+1:1]
  // becomes the new high field, sum[0] enters the low field and the old q0
  // drops into the q_-1 slot.
  always_comb begin
    highExt  = {highField[WIDTH], highField};
    mcandExt = {mcand_i[WIDTH], mcand_i};
    op       = booth_decode({lowField[0], qPrev});
    case (op)
      BOOTH_ADD: sum = highExt + mcandExt;
      BOOTH_SUB: sum = highExt - mcandExt;
      default:   sum = highExt;
    endcase
    acc_o = {sum, lowField};
  end

endmodule

// File: rtl/booth_mult_unit.sv
// Multi-cycle radix-2 Booth multiplier for the HI/LO unit. Handles signed
// (MULT) and unsigned (MULTU) operands by extending both to WIDTH+1 bits and
// running WIDTH+1 Booth iterations on a single datapath. Results are held on
// hi/lo until the next completed operation; kill aborts without touching them.
module booth_mult_unit
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic             kill,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam int ACC_W = 2 * WIDTH + 3;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [WIDTH:0]      mcand_q, mcand_d;
  logic [WIDTH-1:0]    hi_q, hi_d;
  logic [WIDTH-1:0]    lo_q, lo_d;
  logic                done_q, done_d;

  logic [ACC_W-1:0]    accStep;
  logic [WIDTH:0]      extA;
  logic [WIDTH:0]      extB;
  logic                accept;
  logic                lastIter;
  logic                stepping;

  // Operands grow by one bit so that unsigned values look like non-negative
  // signed values; the Booth core then only ever sees two's complement.
  assign extA = {is_signed & op_a[WIDTH-1], op_a};
  assign extB = {is_signed & op_b[WIDTH-1], op_b};

  // A new operation is taken only from IDLE, and kill vetoes it.
  assign accept   = (state_q == IDLE) && start && !kill;
  // cnt_q counts completed iterations; the step taken when it reads WIDTH is
  // the (WIDTH+1)-th and final one.
  assign lastIter = (cnt_q == CNT_W'(WIDTH));
  assign stepping = (state_q == RUN) && !kill;

  booth_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc_i  (acc_q),
    .mcand_i(mcand_q),
    .acc_o  (accStep)
  );

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: kill wins over the final iteration.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start && !kill) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (kill || lastIter) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs: busy follows the state, the rest are registered.
  always_comb begin
    busy = (state_q == RUN);
    done = done_q;
    hi   = hi_q;
    lo   = lo_q;
  end

  // Datapath next-state: load on accept, iterate while running, publish the
  // low 2*WIDTH product bits on the final step.
  always_comb begin
    acc_d   = acc_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    if (accept) begin
      acc_d   = {{(WIDTH + 1){1'b0}}, extA, 1'b0};
      mcand_d = extB;
      cnt_d   = '0;
    end else if (stepping) begin
      acc_d = accStep;
      cnt_d = cnt_q + CNT_W'(1);
      if (lastIter) begin
        hi_d   = accStep[2*WIDTH:WIDTH+1];
        lo_d   = accStep[WIDTH:1];
        done_d = 1'b1;
      end
    end
  end

  // Datapath registers; reset clears results as well as working state.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_booth_mult_unit.sv
// Self-checking bench for booth_mult_unit at WIDTH=32 and WIDTH=8, using a
// plain-arithmetic product model and directed plus random operations.
module tb_booth_mult_unit;

  logic        clock;
  logic        reset;

  logic        start32, sgn32, kill32;
  logic [31:0] a32, b32;
  logic        busy32, done32;
  logic [31:0] hi32, lo32;

  logic        start8, sgn8, kill8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [7:0]  hi8, lo8;

  int checks;
  int errors;

  booth_mult_unit #(.WIDTH(32)) dut32 (
    .clock    (clock),
    .reset    (reset),
    .start    (start32),
    .is_signed(sgn32),
    .kill     (kill32),
    .op_a     (a32),
    .op_b     (b32),
    .busy     (busy32),
    .done     (done32),
    .hi       (hi32),
    .lo       (lo32)
  );

  booth_mult_unit #(.WIDTH(8)) dut8 (
    .clock    (clock),
    .reset    (reset),
    .start    (start8),
    .is_signed(sgn8),
    .kill     (kill8),
    .op_a     (a8),
    .op_b     (b8),
    .busy     (busy8),
    .done     (done8),
    .hi       (hi8),
    .lo       (lo8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference product from ordinary integer arithmetic.
  function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb;
    logic [63:0] ua, ub;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'b0, a};
    ub = {32'b0, b};
    return ua * ub;
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
    int sa, sb;
    if (s) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
    end else begin
      sa = int'({24'b0, a});
      sb = int'({24'b0, b});
    end
    return 16'(sa * sb);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Present one start cycle; returns at the negedge following the accept edge.
  task automatic applyStimulus32(input logic [31:0] a, input logic [31:0] b, input logic s);
    start32 = 1'b1;
    a32 = a;
    b32 = b;
    sgn32 = s;
    @(negedge clock);
    start32 = 1'b0;
    a32 = $urandom;
    b32 = $urandom;
    sgn32 = 1'($urandom);
  endtask

  task automatic applyStimulus8(input logic [7:0] a, input logic [7:0] b, input logic s);
    start8 = 1'b1;
    a8 = a;
    b8 = b;
    sgn8 = s;
    @(negedge clock);
    start8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    sgn8 = 1'($urandom);
  endtask

  // Count edges until done is seen, bounded so a stuck unit cannot hang.
  task automatic waitDone32(output int cyc);
    cyc = 0;
    while (done32 !== 1'b1 && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic waitDone8(output int cyc);
    cyc = 0;
    while (done8 !== 1'b1 && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  // Full operation: start, latency, result, one-cycle done.
  task automatic runOp32(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s);
    int cyc;
    applyStimulus32(a, b, s);
    checkOutput({tag, "_busy"}, 64'(busy32), 64'd1);
    waitDone32(cyc);
    checkOutput({tag, "_lat"}, 64'(cyc), 64'd33);
    checkOutput({tag, "_prod"}, {hi32, lo32}, ref32(a, b, s));
    @(negedge clock);
    checkOutput({tag, "_pulse"}, 64'({busy32, done32}), 64'd0);
  endtask

  task automatic runOp8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic s);
    int cyc;
    applyStimulus8(a, b, s);
    waitDone8(cyc);
    checkOutput({tag, "_lat"}, 64'(cyc), 64'd9);
    checkOutput({tag, "_prod"}, 64'({hi8, lo8}), 64'(ref8(a, b, s)));
    @(negedge clock);
    checkOutput({tag, "_pulse"}, 64'(done8), 64'd0);
  endtask

  initial begin
    int cyc;
    int doneSeen;
    logic [63:0] held;
    logic [31:0] ra, rb;
    logic rs;

    checks = 0;
    errors = 0;
    reset = 1'b1;
    start32 = 0; sgn32 = 0; kill32 = 0; a32 = 0; b32 = 0;
    start8 = 0;  sgn8 = 0;  kill8 = 0;  a8 = 0;  b8 = 0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Reset state.
    checkOutput("rst_busy", 64'(busy32), 64'd0);
    checkOutput("rst_done", 64'(done32), 64'd0);
    checkOutput("rst_hilo", {hi32, lo32}, 64'd0);
    checkOutput("rst8_all", 64'({busy8, done8, hi8, lo8}), 64'd0);

    // Directed products.
    runOp32("s7xm3", 32'd7, 32'hFFFF_FFFD, 1'b1);
    checkOutput("s7xm3_const", {hi32, lo32}, 64'hFFFF_FFFF_FFFF_FFEB);
    runOp32("uffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    checkOutput("uffxff_const", {hi32, lo32}, 64'hFFFF_FFFE_0000_0001);
    runOp32("sffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    checkOutput("sffxff_const", {hi32, lo32}, 64'h0000_0000_0000_0001);
    runOp32("s8x8", 32'h8000_0000, 32'h8000_0000, 1'b1);
    checkOutput("s8x8_const", {hi32, lo32}, 64'h4000_0000_0000_0000);

    // Back-to-back: second start issued in the done cycle.
    applyStimulus32(32'd1234, 32'd5678, 1'b0);
    waitDone32(cyc);
    checkOutput("b2b_first", {hi32, lo32}, ref32(32'd1234, 32'd5678, 1'b0));
    applyStimulus32(32'd5, 32'd6, 1'b0);
    checkOutput("b2b_busy", 64'({busy32, done32}), 64'b10);
    // A start mid-run must be ignored.
    repeat (10) @(negedge clock);
    start32 = 1'b1; a32 = 32'hDEAD_BEEF; b32 = 32'h1234_5678; sgn32 = 1'b1;
    @(negedge clock);
    start32 = 1'b0;
    waitDone32(cyc);
    checkOutput("b2b_lat", 64'(cyc), 64'd22);
    checkOutput("b2b_prod", {hi32, lo32}, 64'd30);
    @(negedge clock);
    checkOutput("b2b_idle", 64'({busy32, done32}), 64'd0);

    // kill mid-run: no done, results retained.
    held = {hi32, lo32};
    applyStimulus32(32'd7, 32'd9, 1'b0);
    repeat (9) @(negedge clock);
    kill32 = 1'b1;
    @(negedge clock);
    kill32 = 1'b0;
    checkOutput("kill_busy", 64'({busy32, done32}), 64'd0);
    doneSeen = 0;
    repeat (40) begin
      @(negedge clock);
      if (done32 === 1'b1) doneSeen++;
    end
    checkOutput("kill_nodone", 64'(doneSeen), 64'd0);
    checkOutput("kill_hold", {hi32, lo32}, held);

    // kill on the edge that would complete the final iteration.
    applyStimulus32(32'd11, 32'd13, 1'b0);
    repeat (32) @(negedge clock);
    kill32 = 1'b1;
    @(negedge clock);
    kill32 = 1'b0;
    checkOutput("killlast_flags", 64'({busy32, done32}), 64'd0);
    checkOutput("killlast_hold", {hi32, lo32}, held);

    // kill in IDLE blocks a simultaneous start.
    start32 = 1'b1; kill32 = 1'b1; a32 = 32'd3; b32 = 32'd3;
    @(negedge clock);
    start32 = 1'b0; kill32 = 1'b0;
    checkOutput("killidle_busy", 64'(busy32), 64'd0);

    // reset mid-run clears everything including hi/lo.
    applyStimulus32(32'd100, 32'd200, 1'b0);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkOutput("rstmid_flags", 64'({busy32, done32}), 64'd0);
    checkOutput("rstmid_hilo", {hi32, lo32}, 64'd0);

    // Random operations against the model.
    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom);
      if (i == 0) ra = 32'h7FFF_FFFF;
      if (i == 1) rb = 32'h8000_0000;
      runOp32($sformatf("rnd32_%0d", i), ra, rb, rs);
    end

    // Narrow instance.
    runOp8("w8_s128", 8'h80, 8'h80, 1'b1);
    checkOutput("w8_s128_const", 64'({hi8, lo8}), 64'h4000);
    runOp8("w8_u200x3", 8'd200, 8'd3, 1'b0);
    checkOutput("w8_u200x3_const", 64'({hi8, lo8}), 64'h0258);
    for (int i = 0; i < 10; i++) begin
      runOp8($sformatf("rnd8_%0d", i), 8'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
